uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter hold register among NUM_REQ byte sources,
// with optional packet locking and a txrdy acknowledge timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter bit LOCK_EN     = 1'b1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 txrdy,
  output logic [7:0]           tx_data,
  output logic                 tx_load,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 locked,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {ARB, LOAD, ACK_WAIT, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_load_q, tx_load_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [7:0]       win_data;
  logic             win_last;

  // While locked only the owner may win; otherwise search from ptr+1 upwards.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (locked_q) begin
      if (req_valid[grant_idx_q]) begin
        win_vld = 1'b1;
        win_idx = grant_idx_q;
      end
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!win_vld && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
          win_vld = 1'b1;
          win_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
        end
      end
    end
    win_data = req_data[8*win_idx +: 8];
    win_last = req_last[win_idx];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    tx_data_d   = tx_data_q;
    locked_d    = locked_q;
    cnt_d       = cnt_q;
    tx_load_d   = 1'b0;
    err_d       = 1'b0;
    req_ready   = '0;

    case (state_q)
      ARB: begin
        if (txrdy && win_vld) begin
          req_ready[win_idx] = 1'b1;
          tx_data_d          = win_data;
          grant_idx_d        = win_idx;
          ptr_d              = win_idx;
          locked_d           = LOCK_EN & ~win_last;
          tx_load_d          = 1'b1;
          state_d            = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (!txrdy) begin
          state_d = DRAIN;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Transmitter never took the byte: drop it but keep any packet lock.
          err_d   = 1'b1;
          state_d = ARB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (txrdy) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ARB;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      grant_idx_q <= '0;
      tx_data_q   <= '0;
      tx_load_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_load     = tx_load_q;
  assign grant_idx   = grant_idx_q;
  assign locked      = locked_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle comparison against a transaction-timing
// model, directed scenarios with literal expectations, then randomized traffic.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int IDX_W       = 2;
  localparam bit LOCK_EN     = 1'b1;
  localparam int ACK_TIMEOUT = 16;
  localparam int MODE_AUTO   = 0;
  localparam int MODE_MANUAL = 1;

  logic                 clk = 1'b0;
  logic                 aresetn = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 txrdy = 1'b1;
  logic [7:0]           tx_data;
  logic                 tx_load;
  logic [IDX_W-1:0]     grant_idx;
  logic                 locked;
  logic                 busy;
  logic                 err_timeout;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .LOCK_EN(LOCK_EN), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .aresetn(aresetn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .txrdy(txrdy), .tx_data(tx_data),
    .tx_load(tx_load), .grant_idx(grant_idx), .locked(locked), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Observed loads and events, collected by the compare process.
  int         log_idx[$];
  logic [7:0] log_data[$];
  logic       log_lock[$];
  int         log_cyc[$];
  int         err_cyc = -1;
  logic       err_busy = 1'b0;
  int         ready_seen = 0;

  // Transaction-timing model: idle/waiting, cycles since the last accept, drain flag.
  bit         m_idle = 1'b1;
  int         m_since = 0;
  bit         m_drain = 1'b0;
  int         m_ptr = NUM_REQ - 1;
  int         m_gidx = 0;
  bit         m_lock = 1'b0;
  logic [7:0] m_data = '0;
  bit         m_load = 1'b0;
  bit         m_err = 1'b0;

  always @(negedge clk) begin
    int                 win;
    int                 c;
    logic [NUM_REQ-1:0] exp_ready;
    if (!aresetn) begin
      m_idle = 1'b1; m_since = 0; m_drain = 1'b0; m_ptr = NUM_REQ - 1;
      m_gidx = 0; m_lock = 1'b0; m_data = '0; m_load = 1'b0; m_err = 1'b0;
    end
    win = -1;
    if (m_idle) begin
      if (m_lock) begin
        if (req_valid[m_gidx]) win = m_gidx;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (m_ptr + k) % NUM_REQ;
          if (win < 0 && req_valid[c]) win = c;
        end
      end
    end
    exp_ready = '0;
    if (aresetn && m_idle && txrdy && win >= 0) exp_ready[win] = 1'b1;

    check("req_ready",    32'(req_ready),   32'(exp_ready));
    check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    check("tx_load",      32'(tx_load),     32'(m_load));
    check("tx_data",      32'(tx_data),     32'(m_data));
    check("grant_idx",    32'(grant_idx),   32'(m_gidx));
    check("locked",       32'(locked),      32'(m_lock));
    check("busy",         32'(busy),        32'(!m_idle));
    check("err_timeout",  32'(err_timeout), 32'(m_err));

    if (aresetn) begin
      if (tx_load) begin
        log_idx.push_back(int'(grant_idx));
        log_data.push_back(tx_data);
        log_lock.push_back(locked);
        log_cyc.push_back(cyc);
      end
      if (err_timeout) begin
        err_cyc  = cyc;
        err_busy = busy;
      end
      if (req_ready != '0) ready_seen++;

      m_load = 1'b0;
      m_err  = 1'b0;
      if (m_idle) begin
        if (exp_ready != '0) begin
          m_data  = req_data[8*win +: 8];
          m_gidx  = win;
          m_ptr   = win;
          m_lock  = LOCK_EN && !req_last[win];
          m_load  = 1'b1;
          m_idle  = 1'b0;
          m_since = 1;
          m_drain = 1'b0;
        end
      end else if (m_since == 1) begin
        m_since = 2;
      end else if (m_drain) begin
        if (txrdy) m_idle = 1'b1;
      end else if (!txrdy) begin
        m_drain = 1'b1;
      end else if (m_since == ACK_TIMEOUT + 1) begin
        m_err  = 1'b1;
        m_idle = 1'b1;
      end else begin
        m_since++;
      end
    end
  end

  // Requester byte queues ({last, data}) and a simple transmitter emulation.
  logic [8:0] rq [NUM_REQ][$];
  int tx_mode  = MODE_AUTO;
  int busy_fix = 20;
  int tx_cnt   = 0;
  int rel_cyc  = 0;

  task automatic apply_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = rq[i][0][7:0];
        req_last[i]         = rq[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] hs;
    logic               ld;
    int                 n;
    @(negedge clk);
    hs = req_valid & req_ready;
    ld = tx_load;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    if (tx_mode == MODE_AUTO) begin
      if (ld) begin
        n = (busy_fix >= 0) ? busy_fix : int'($urandom_range(0, 6));
        if (n > 0) begin
          txrdy  = 1'b0;
          tx_cnt = n;
        end
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) txrdy = 1'b1;
      end
    end
    apply_reqs();
  endtask

  task automatic assert_reset();
    aresetn = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    tx_cnt = 0;
    txrdy  = 1'b1;
    log_idx.delete(); log_data.delete(); log_lock.delete(); log_cyc.delete();
    err_cyc    = -1;
    ready_seen = 0;
    apply_reqs();
  endtask

  task automatic release_reset();
    aresetn = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    for (int b = 0; b < budget && log_idx.size() < n; b++) step();
    check({name, "_load_count"}, 32'(log_idx.size()), 32'(n));
  endtask

  int         rr_idx [5] = '{0, 1, 2, 3, 0};
  logic [7:0] rr_dat [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  int         lk_idx [4] = '{2, 2, 2, 3};
  logic [7:0] lk_dat [4] = '{8'hA1, 8'hA2, 8'hA3, 8'h33};
  logic       lk_lck [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int x;
    int r;
    // Reset, first accept and round-robin order.
    assert_reset();
    step(); step();
    tx_mode = MODE_AUTO; busy_fix = 20;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < NUM_REQ; i++) rq[i].push_back({1'b1, 8'(8'h10 + i)});
    apply_reqs();
    release_reset();
    wait_log(5, 400, "rr");
    check("first_load_cycle", 32'(log_cyc[0]), 32'(rel_cyc + 1));
    for (int j = 0; j < 5; j++) begin
      check("rr_grant", 32'(log_idx[j]), 32'(rr_idx[j]));
      check("rr_data",  32'(log_data[j]), 32'(rr_dat[j]));
    end

    // Packet lock on requester 2 while the others wait.
    assert_reset();
    step(); step();
    tx_mode = MODE_AUTO; busy_fix = 5;
    rq[2].push_back({1'b0, 8'hA1});
    rq[2].push_back({1'b0, 8'hA2});
    rq[2].push_back({1'b1, 8'hA3});
    apply_reqs();
    release_reset();
    wait_log(1, 100, "lock_first");
    for (int i = 0; i < NUM_REQ; i++)
      if (i != 2) begin
        rq[i].push_back({1'b1, 8'(8'h30 + i)});
        rq[i].push_back({1'b1, 8'(8'h30 + i)});
      end
    apply_reqs();
    wait_log(4, 200, "lock");
    for (int j = 0; j < 4; j++) begin
      check("lock_grant", 32'(log_idx[j]), 32'(lk_idx[j]));
      check("lock_data",  32'(log_data[j]), 32'(lk_dat[j]));
      check("lock_flag",  32'(log_lock[j]), 32'(lk_lck[j]));
    end

    // txrdy never falls after the load.
    assert_reset();
    step(); step();
    tx_mode = MODE_MANUAL; txrdy = 1'b1;
    rq[1].push_back({1'b1, 8'h5C});
    apply_reqs();
    release_reset();
    for (int b = 0; b < 100 && err_cyc < 0; b++) step();
    check("timeout_seen",  32'(err_cyc >= 0), 32'd1);
    check("timeout_delay", 32'(err_cyc - log_cyc[0]), 32'd17);
    check("timeout_busy",  32'(err_busy), 32'd0);
    check("timeout_loads", 32'(log_idx.size()), 32'd1);

    // Transmitter busy for 50 cycles: nothing may be accepted.
    assert_reset();
    step(); step();
    tx_mode = MODE_MANUAL; txrdy = 1'b0;
    rq[1].push_back({1'b1, 8'h77});
    apply_reqs();
    release_reset();
    repeat (50) step();
    check("stall_loads", 32'(log_idx.size()), 32'd0);
    check("stall_ready", 32'(ready_seen), 32'd0);
    txrdy = 1'b1;
    x = cyc;
    wait_log(1, 10, "stall_release");
    check("stall_load_cycle", 32'(log_cyc[0]), 32'(x + 1));
    check("stall_grant",      32'(log_idx[0]), 32'd1);

    // Reset asserted while draining a locked packet byte.
    assert_reset();
    step(); step();
    tx_mode = MODE_AUTO; busy_fix = 30;
    rq[2].push_back({1'b0, 8'h99});
    apply_reqs();
    release_reset();
    wait_log(1, 50, "midop");
    step(); step();
    check("midop_busy_before",   32'(busy),   32'd1);
    check("midop_locked_before", 32'(locked), 32'd1);
    aresetn = 1'b0;
    #1;
    check("midop_tx_load", 32'(tx_load), 32'd0);
    check("midop_busy",    32'(busy),    32'd0);
    check("midop_locked",  32'(locked),  32'd0);
    assert_reset();
    step(); step();
    for (int i = 0; i < NUM_REQ; i++) rq[i].push_back({1'b1, 8'(8'h40 + i)});
    apply_reqs();
    release_reset();
    wait_log(1, 20, "midop_restart");
    check("midop_restart_grant", 32'(log_idx[0]),  32'd0);
    check("midop_restart_data",  32'(log_data[0]), 32'h40);

    // Randomized traffic with random packet boundaries and transmitter timing.
    assert_reset();
    step(); step();
    tx_mode = MODE_AUTO; busy_fix = -1;
    release_reset();
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) begin
        r = int'($urandom_range(0, NUM_REQ - 1));
        if (rq[r].size() < 4) rq[r].push_back({1'($urandom_range(0, 1)), 8'($urandom)});
        apply_reqs();
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
